uart_rx_framer: RTL and testbench

Parametrised UART receive framer: synchronises the serial `rx` line, detects start bits on an oversampling tick, samples each bit at mid-point, checks parity and stop bits, and presents the received word on a valid/ready output register. It replaces the fixed 11-bit externally-shifted receive register in the UART receive path. Bit timing, frame assembly and error detection are all internal. Only the oversampling tick comes from the shared baud generator.

---
 rtl/uart_rx_framer_if.sv | 28 ++
 rtl/uart_rx_framer.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_framer_if.sv
// Receive-side output bus of the UART framer.
//   data_out   : received word, LSB = first data bit on the line
//   valid      : data_out and flags hold an unread frame
//   ready      : consumer accepts on valid && ready at a clk edge
//   parity_err : parity mismatch for the frame in data_out
//   frame_err  : a stop bit was sampled low for the frame in data_out
//   overrun    : one-cycle pulse, a completed frame was dropped
// master = framer side, slave = consumer side.
interface uart_rx_framer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data_out, valid, parity_err, frame_err, overrun,
        input  ready
    );

    modport slave (
        input  data_out, valid, parity_err, frame_err, overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronises rx, finds the start bit on the
// oversample tick, samples every bit at its mid-point, checks parity and
// stop bits and holds the word in a valid/ready output register.
// Ports:
//   clk    : system clock
//   preset : asynchronous active-low reset
//   tick   : oversample enable, OVERSAMPLE pulses per bit period
//   rx     : asynchronous serial input, idle high
//   busy   : high whenever the receiver is not idle
//   bus    : output register and handshake (uart_rx_framer_if.master)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for a low sample on a tick
// S_START  | counting to the start-bit mid-point to reject glitches
// S_DATA   | sampling DATA_BITS data bits, LSB first
// S_PARITY | sampling the parity bit
// S_STOP   | sampling STOP_BITS stop bits, last one completes the frame
// S_BREAK  | line held low after the frame, waiting for it to go high
module uart_rx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic preset,
    input  logic tick,
    input  logic rx,
    output logic busy,
    uart_rx_framer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    localparam int             TW          = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  T_HALF      = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  T_FULL      = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]     B_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     B_STOP_LAST = 4'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic                   rxs;
    logic [TW-1:0]          tcnt_q;
    logic [3:0]             bcnt_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   par_acc_q;
    logic                   par_bad_q;
    logic                   fe_acc_q;
    logic                   at_half;
    logic                   at_full;
    logic                   samp;
    logic                   complete;
    logic                   load;
    logic                   ovr_d;
    logic                   start_go;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rxs     = sync_q[1];
    assign at_half = (tcnt_q == T_HALF);
    assign at_full = (tcnt_q == T_FULL);

    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (tick && !rxs) state_d = S_START;
            end
            S_START: begin
                if (tick && at_half) state_d = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && at_full && bcnt_q == B_DATA_LAST)
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (tick && at_full) state_d = S_STOP;
            end
            S_STOP: begin
                // A low final stop sample means the line may be in break.
                if (tick && at_full && bcnt_q == B_STOP_LAST)
                    state_d = rxs ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (tick && rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        start_go = (state_q == S_IDLE) && (state_d == S_START);
        // After the start mid-point every full bit period lands mid-bit.
        samp     = tick && at_full &&
                   (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP);
        complete = samp && (state_q == S_STOP) && (bcnt_q == B_STOP_LAST);
        load     = complete && (!bus.valid || bus.ready);
        ovr_d    = complete && bus.valid && !bus.ready;
    end

    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            tcnt_q         <= '0;
            bcnt_q         <= '0;
            shreg_q        <= '0;
            par_acc_q      <= 1'b0;
            par_bad_q      <= 1'b0;
            fe_acc_q       <= 1'b0;
            bus.data_out   <= '0;
            bus.valid      <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            if (tick) begin
                if (state_q == S_IDLE || state_q == S_BREAK ||
                    state_d != state_q || at_full) begin
                    tcnt_q <= '0;
                end else begin
                    tcnt_q <= tcnt_q + TW'(1);
                end

                if (state_d != state_q) begin
                    bcnt_q <= '0;
                end else if (samp) begin
                    bcnt_q <= bcnt_q + 4'd1;
                end
            end

            if (start_go) begin
                par_acc_q <= 1'b0;
                par_bad_q <= 1'b0;
                fe_acc_q  <= 1'b0;
            end

            if (samp) begin
                case (state_q)
                    S_DATA: begin
                        shreg_q   <= {rxs, shreg_q[DATA_BITS-1:1]};
                        par_acc_q <= par_acc_q ^ rxs;
                    end
                    S_PARITY: begin
                        // par_acc ^ rxs is the weight parity of data + parity bit.
                        par_bad_q <= (PARITY == 1) ? ~(par_acc_q ^ rxs)
                                                   :  (par_acc_q ^ rxs);
                    end
                    S_STOP: begin
                        if (!rxs) fe_acc_q <= 1'b1;
                    end
                    default: ;
                endcase
            end

            bus.overrun <= ovr_d;

            if (load) begin
                bus.data_out   <= shreg_q;
                bus.parity_err <= (PARITY != 0) && par_bad_q;
                bus.frame_err  <= fe_acc_q || !rxs;
                bus.valid      <= 1'b1;
            end else if (bus.valid && bus.ready) begin
                bus.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
module tb_uart_rx_framer;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       preset;
    logic       tick;
    logic [2:0] rx;
    logic       busy0, busy1, busy2;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int tstart = 0;
    logic mid_busy;

    logic [10:0] q0[$], q1[$], q2[$];
    int          c0[$], c1[$], c2[$];
    int ov0 = 0, ov1 = 0, ov2 = 0;
    int vh0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_framer_if #(.DATA_BITS(8)) b0 ();
    uart_rx_framer_if #(.DATA_BITS(8)) b1 ();
    uart_rx_framer_if #(.DATA_BITS(5)) b2 ();

    uart_rx_framer u0 (
        .clk(clk), .preset(preset), .tick(tick), .rx(rx[0]), .busy(busy0), .bus(b0)
    );
    uart_rx_framer #(.PARITY(2)) u1 (
        .clk(clk), .preset(preset), .tick(tick), .rx(rx[1]), .busy(busy1), .bus(b1)
    );
    uart_rx_framer #(.DATA_BITS(5), .STOP_BITS(2)) u2 (
        .clk(clk), .preset(preset), .tick(tick), .rx(rx[2]), .busy(busy2), .bus(b2)
    );

    // Collect handshakes; sampled mid-cycle, the handshake occurs at the next edge.
    always @(negedge clk) begin
        if (b0.valid) vh0 <= vh0 + 1;
        if (b0.overrun) ov0 <= ov0 + 1;
        if (b1.overrun) ov1 <= ov1 + 1;
        if (b2.overrun) ov2 <= ov2 + 1;
        if (b0.valid && b0.ready) begin
            q0.push_back({b0.parity_err, b0.frame_err, 1'b0, b0.data_out});
            c0.push_back(cyc);
        end
        if (b1.valid && b1.ready) begin
            q1.push_back({b1.parity_err, b1.frame_err, 1'b0, b1.data_out});
            c1.push_back(cyc);
        end
        if (b2.valid && b2.ready) begin
            q2.push_back({b2.parity_err, b2.frame_err, 4'b0, b2.data_out});
            c2.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cyc(input bit gaps);
        if (gaps && $urandom_range(0, 3) == 0) begin
            tick = 1'b0;
            step();
        end
        tick = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        rx   = 3'b111;
        tick = 1'b1;
        repeat (n) step();
    endtask

    function automatic logic busy_of(input int which);
        case (which)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic [8:0] mask_bits(input logic [8:0] d, input int nbits);
        logic [8:0] m;
        m = 9'h1ff >> (9 - nbits);
        return d & m;
    endfunction

    // Line-level parity bit to transmit: correct for the mode unless flipped.
    function automatic logic tx_par(input logic [8:0] d, input int pmode, input bit flip);
        logic p;
        p = (pmode == 1) ? ~(^d) : (^d);
        return p ^ flip;
    endfunction

    // Expected receive result from the frame as it was put on the line.
    function automatic logic [10:0] model(input logic [8:0] data, input int nbits,
                                          input int pmode, input bit flip,
                                          input int nstop, input logic [1:0] stopv);
        logic [8:0] d;
        int         w;
        logic       pe, fe;
        d  = mask_bits(data, nbits);
        w  = $countones(d) + ((pmode != 0) ? int'(tx_par(d, pmode, flip)) : 0);
        pe = (pmode == 1) ? (w % 2 == 0) : (pmode == 2) ? (w % 2 == 1) : 1'b0;
        fe = (stopv[0] == 1'b0) || (nstop == 2 && stopv[1] == 1'b0);
        return {pe, fe, d};
    endfunction

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int pmode, input bit flip, input int nstop,
                              input logic [1:0] stopv, input bit gaps);
        logic       bits[$];
        logic [8:0] d;
        d = mask_bits(data, nbits);
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
        if (pmode != 0) bits.push_back(tx_par(d, pmode, flip));
        for (int i = 0; i < nstop; i++) bits.push_back(stopv[i]);
        for (int j = 0; j < bits.size(); j++) begin
            rx[which] = bits[j];
            if (j == 0) tstart = cyc;
            repeat (OS) tick_cyc(gaps);
            if (j == 3) mid_busy = busy_of(which);
        end
    endtask

    task automatic expect_frame(input string tag, input int which,
                                input logic [10:0] exp, output int tcap);
        int          n;
        logic [10:0] got;
        tcap = 0;
        case (which)
            0:       n = q0.size();
            1:       n = q1.size();
            default: n = q2.size();
        endcase
        chk({tag, "_count"}, n, 1);
        if (n > 0) begin
            case (which)
                0:       begin got = q0.pop_front(); tcap = c0.pop_front(); end
                1:       begin got = q1.pop_front(); tcap = c1.pop_front(); end
                default: begin got = q2.pop_front(); tcap = c2.pop_front(); end
            endcase
            chk({tag, "_data"}, got[8:0], exp[8:0]);
            chk({tag, "_flags"}, got[10:9], exp[10:9]);
        end
    endtask

    initial begin
        int         tc;
        int         vbase, obase;
        int         which, nbits, pmode, nstop;
        logic [8:0] rdata;
        bit         rflip;
        logic [1:0] rstop;

        preset   = 1'b0;
        tick     = 1'b1;
        rx       = 3'b111;
        b0.ready = 1'b1;
        b1.ready = 1'b1;
        b2.ready = 1'b1;
        repeat (3) step();
        chk("reset_u0", {b0.data_out, b0.valid, b0.parity_err, b0.frame_err, b0.overrun, busy0}, 0);
        chk("reset_u1", {b1.data_out, b1.valid, b1.parity_err, b1.frame_err, b1.overrun, busy1}, 0);
        chk("reset_u2", {b2.data_out, b2.valid, b2.parity_err, b2.frame_err, b2.overrun, busy2}, 0);
        preset = 1'b1;
        idle(2 * OS);

        // 8N1 0xA5 with exact completion latency (2 sync + 1 detect + frame)
        vbase = vh0;
        send_frame(0, 9'h0A5, 8, 0, 0, 1, 2'b11, 0);
        chk("a5_busy_mid", mid_busy, 1);
        idle(2 * OS);
        expect_frame("a5", 0, model(9'h0A5, 8, 0, 0, 1, 2'b11), tc);
        chk("a5_latency", tc - tstart, 3 + (1 + 8) * OS + OS / 2);
        chk("a5_valid_cycles", vh0 - vbase, 1);
        chk("a5_idle_after", {busy0, b0.valid}, 0);

        // Even parity, wrong then right parity bit
        send_frame(1, 9'h0A5, 8, 2, 1, 1, 2'b11, 0);
        idle(2 * OS);
        expect_frame("par_bad", 1, {1'b1, 1'b0, 9'h0A5}, tc);
        chk("par_latency", tc - tstart, 3 + (1 + 8 + 1) * OS + OS / 2);
        send_frame(1, 9'h0A5, 8, 2, 0, 1, 2'b11, 0);
        idle(2 * OS);
        expect_frame("par_ok", 1, {1'b0, 1'b0, 9'h0A5}, tc);

        // 4-cycle glitch must be rejected, then a normal frame
        rx[0] = 1'b0;
        repeat (4) step();
        idle(3 * OS);
        chk("glitch_frames", q0.size(), 0);
        chk("glitch_idle", {busy0, b0.valid}, 0);
        send_frame(0, 9'h03C, 8, 0, 0, 1, 2'b11, 0);
        idle(2 * OS);
        expect_frame("after_glitch", 0, model(9'h03C, 8, 0, 0, 1, 2'b11), tc);

        // Overrun: consumer stalled across two frames
        b0.ready = 1'b0;
        obase    = ov0;
        send_frame(0, 9'h011, 8, 0, 0, 1, 2'b11, 0);
        idle(OS);
        chk("ovr_first_held", {b0.valid, b0.data_out}, {1'b1, 8'h11});
        chk("ovr_none_yet", ov0 - obase, 0);
        send_frame(0, 9'h022, 8, 0, 0, 1, 2'b11, 0);
        idle(2 * OS);
        chk("ovr_pulses", ov0 - obase, 1);
        chk("ovr_kept", {b0.valid, b0.data_out}, {1'b1, 8'h11});
        b0.ready = 1'b1;
        step();
        chk("ovr_valid_clear", b0.valid, 0);
        expect_frame("ovr_read", 0, {2'b00, 9'h011}, tc);

        // Low stop bit, then line held low for 40 bit times
        send_frame(0, 9'h000, 8, 0, 0, 1, 2'b00, 0);
        repeat (40 * OS) step();
        chk("break_busy", busy0, 1);
        idle(2 * OS);
        expect_frame("break", 0, {1'b0, 1'b1, 9'h000}, tc);
        send_frame(0, 9'h07E, 8, 0, 0, 1, 2'b11, 0);
        idle(2 * OS);
        expect_frame("after_break", 0, model(9'h07E, 8, 0, 0, 1, 2'b11), tc);

        // Reset in the middle of the data bits of 0xFF
        rx[0] = 1'b0;
        repeat (OS) tick_cyc(0);
        rx[0] = 1'b1;
        repeat (3 * OS) tick_cyc(0);
        chk("rst_mid_busy", busy0, 1);
        preset = 1'b0;
        #1;
        chk("rst_mid_out", {b0.data_out, b0.valid, b0.parity_err, b0.frame_err, b0.overrun, busy0}, 0);
        idle(3);
        preset = 1'b1;
        idle(10 * OS);
        chk("rst_mid_frames", q0.size(), 0);
        send_frame(0, 9'h081, 8, 0, 0, 1, 2'b11, 0);
        idle(2 * OS);
        expect_frame("after_rst", 0, model(9'h081, 8, 0, 0, 1, 2'b11), tc);

        // 5 data bits, 2 stop bits
        send_frame(2, 9'h015, 5, 0, 0, 2, 2'b11, 0);
        idle(2 * OS);
        expect_frame("d5s2", 2, {2'b00, 9'h015}, tc);
        chk("d5s2_latency", tc - tstart, 3 + (1 + 5) * OS + OS / 2 + OS);

        // Randomised frames with tick gaps against the model
        for (int n = 0; n < 12; n++) begin
            which = $urandom_range(0, 2);
            nbits = (which == 2) ? 5 : 8;
            pmode = (which == 1) ? 2 : 0;
            nstop = (which == 2) ? 2 : 1;
            rdata = 9'($urandom);
            rflip = (which == 1) && ($urandom_range(0, 2) == 0);
            rstop = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            send_frame(which, rdata, nbits, pmode, rflip, nstop, rstop, 1);
            idle(2 * OS);
            expect_frame($sformatf("rand%0d", n), which,
                         model(rdata, nbits, pmode, rflip, nstop, rstop), tc);
        end
        chk("rand_no_overrun", ov0 + ov1 + ov2 - obase, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
